// File: rtl/watch_fnd_pkg.sv
// Shared constants for the watch FND driver: active-low segment patterns,
// blank code, decimal-point bit position and digit-select indices.
package watch_fnd_pkg;

  // Patterns ordered {dp,g,f,e,d,c,b,a}, active-low, dp off
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam int         DP_BIT    = 7;

  localparam logic [1:0] DIGIT_0 = 2'd0;
  localparam logic [1:0] DIGIT_1 = 2'd1;
  localparam logic [1:0] DIGIT_2 = 2'd2;
  localparam logic [1:0] DIGIT_3 = 2'd3;

  function automatic logic [7:0] seg_of(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/watch_fnd_ctrl_bcd_decoder.sv
// fnd_bcd_decoder: one decimal digit plus dp enable to an active-low
// 7-segment pattern; codes 10..15 blank the digit entirely.
module fnd_bcd_decoder
  import watch_fnd_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_dp_en,
  output logic [7:0] o_seg
);

  logic [7:0] w_seg;

  always_comb begin
    w_seg = seg_of(i_digit);
    if ((i_digit <= 4'd9) && i_dp_en) begin
      w_seg[DP_BIT] = 1'b0;
    end
  end

  assign o_seg = w_seg;

endmodule

// File: rtl/watch_fnd_ctrl.sv
// 4-digit common-anode FND scanner showing sec.msec or hour.minute.
// Define FND_DOT_BLINK_EN to blink the separator dot at 1 Hz from i_msec.
module watch_fnd_ctrl
  import watch_fnd_pkg::*;
#(
  parameter int SCAN_COUNT = 100_000
)(
  input  logic       clk,
  input  logic       p_rst,
  input  logic       i_mode,
  input  logic [6:0] i_msec,
  input  logic [5:0] i_sec,
  input  logic [5:0] i_minute,
  input  logic [4:0] i_hour,
  output logic [3:0] o_fnd_com,
  output logic [7:0] o_fnd_data
);

  localparam int                CNT_W    = (SCAN_COUNT > 2) ? $clog2(SCAN_COUNT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_COUNT - 1);

  logic [CNT_W-1:0] r_scan_cnt;
  logic [1:0]       r_sel;
  logic             w_tick;

  assign w_tick = (r_scan_cnt == CNT_LAST);

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge value of its neighbours; the async reset sits in the list.
  always_ff @(posedge clk or posedge p_rst) begin
    if (p_rst) begin
      r_scan_cnt <= '0;
      r_sel      <= DIGIT_0;
    end else begin
      r_scan_cnt <= w_tick ? '0 : r_scan_cnt + CNT_W'(1);
      if (w_tick) begin
        r_sel <= r_sel + 2'd1;
      end
    end
  end

  // Pick the field for the current digit pair; each field fits in 7 bits
  logic [6:0] w_field;
  logic       w_tens_pos;
  logic [3:0] w_digit;
  logic       w_dp_en;
  logic [7:0] w_seg;

  always_comb begin
    w_field    = '0;
    w_tens_pos = r_sel[0];
    case ({i_mode, r_sel[1]})
      2'b00:   w_field = i_msec;
      2'b01:   w_field = {1'b0, i_sec};
      2'b10:   w_field = {1'b0, i_minute};
      default: w_field = {2'b00, i_hour};
    endcase
    w_digit = w_tens_pos ? 4'((w_field / 7'd10) % 7'd10) : 4'(w_field % 7'd10);
  end

`ifdef FND_DOT_BLINK_EN
  assign w_dp_en = (r_sel == DIGIT_2) && (i_msec < 7'd50);
`else
  assign w_dp_en = (r_sel == DIGIT_2);
`endif

  fnd_bcd_decoder u_decoder (
    .i_digit (w_digit),
    .i_dp_en (w_dp_en),
    .o_seg   (w_seg)
  );

  always_ff @(posedge clk or posedge p_rst) begin
    if (p_rst) begin
      o_fnd_com  <= 4'b1111;
      o_fnd_data <= SEG_BLANK;
    end else begin
      o_fnd_com  <= ~(4'b0001 << r_sel);
      o_fnd_data <= w_seg;
    end
  end

endmodule

// File: doc/watch_fnd_ctrl.md
Name: watch_fnd_ctrl

Overview:
Downstream consumer of the watch datapath's msec/sec/minute/hour counters. Drives a 4-digit common-anode 7-segment display (FND) by time-multiplexing the digits. i_mode selects which pair of fields is shown: sec.msec or hour.minute. It has a free-running scan-tick counter, a 2-bit digit selector, binary-to-decimal digit split, and registered segment/common outputs.

Parameters:
SCAN_COUNT, 100_000, clk cycles per digit (1 kHz digit rate at 100 MHz); must be >= 2

Ports:
clk  input  1  system clock, 100 MHz
p_rst  input  1  reset, asynchronous, active-high
i_mode  input  1  0: show sec.msec; 1: show hour.minute
i_msec  input  7  0..99, centiseconds
i_sec  input  6  0..59
i_minute  input  6  0..59
i_hour  input  5  0..23
o_fnd_com  output  4  digit enables, active-low; bit0 is the rightmost digit
o_fnd_data  output  8  segments, active-low, ordered {dp,g,f,e,d,c,b,a}

Behaviour:
- Reset (async, while p_rst=1): scan counter=0, sel=0, o_fnd_com=4'b1111, o_fnd_data=8'hFF (blank).
- Scan counter: counts 0..SCAN_COUNT-1 and then wraps to 0. It raises an internal 1-cycle tick on the terminal count.
- Digit selector sel: 2-bit register. Increments by 1 on each tick and wraps 3->0.
- Field mapping, mode 0: sel0=msec ones, sel1=msec tens, sel2=sec ones, sel3=sec tens.
- Field mapping, mode 1: sel0=minute ones, sel1=minute tens, sel2=hour ones, sel3=hour tens.
- Digit split: ones = v mod 10. tens = (v/10) mod 10. Out-of-range input is not an error; for example msec=127 gives tens=2, ones=7.
- Decode, hex with dp off: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
- Decimal point: on sel2 only, bit7 is cleared (the separator between the two fields). It is off on all other digits.
- Outputs are registered every clk from the current sel, i_mode and inputs. Latency from any input or sel change to the outputs is 1 clk.
- o_fnd_com = ~(1<<sel). Exactly one digit is low at any time after reset.
- The first clk edge after p_rst deasserts gives o_fnd_com=1110.
- i_mode change mid-digit: the new mapping appears 1 clk later. The scan position is not disturbed.
- Reset asserted mid-scan: outputs blank immediately (asynchronous). Scanning resumes at sel0 with a full SCAN_COUNT period.

Optional Feature:
Macro FND_DOT_BLINK_EN.
- Defined: the sel2 dp is lit only while i_msec < 50, giving a 1 Hz, 50% blink.
- Undefined: the sel2 dp is always lit.
- All other behaviour is identical in both builds.

Decomposition:
- Package watch_fnd_pkg holds:
  - the ten segment-pattern constants
  - SEG_BLANK = 8'hFF
  - DP_BIT = 7
  - DIGIT_* select indices
- One sub-module, fnd_bcd_decoder: 4-bit digit plus dp-enable in, 8-bit active-low pattern out. Codes 10..15 decode to SEG_BLANK.
- Scan counter, selector, and field mux stay in watch_fnd_ctrl.

Test Plan:
Benches use SCAN_COUNT=4.
1. Reset behaviour: hold p_rst -> com=1111, data=FF. Release -> after 1 clk com=1110, and each digit is held for 4 clk.
2. Mode 0 display: mode=0, msec=37, sec=45 -> per scan slot (com/data): 1110/F8, 1101/B0, 1011/12, 0111/99. Then wrap to 1110.
3. Mode 1 display: mode=1, hour=12, minute=08 -> 1110/80, 1101/C0, 1011/24, 0111/F9.
4. Mode switch: toggle i_mode while sel=1 -> data changes 1 clk later, com is unchanged, and the slot length is still 4 clk.
5. Async reset mid-scan: assert p_rst asynchronously while sel=2 -> outputs go to 1111/FF without a clk edge. After release the scan restarts at 1110.
6. Blink (FND_DOT_BLINK_EN defined): mode 0, sec=5. With msec=60 -> sel2 data=92; with msec=10 -> sel2 data=12. With the macro undefined, msec=60 -> 12.
